// File: rtl/lsu_mem_switch.sv
// lsu_mem_switch: routes per-lane LSU requests to dcache or shared memory through
// 2-entry lane buffers, and merges both response streams via a round-robin output register.
module lsu_mem_switch #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 16,
    parameter int SEL_BIT   = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_LANES-1:0]                 in_req_valid,
    input  logic [NUM_LANES-1:0]                 in_req_rw,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0]     in_req_addr,
    input  logic [NUM_LANES-1:0][DATA_W/8-1:0]   in_req_byteen,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]     in_req_data,
    input  logic [NUM_LANES-1:0][TAG_W-1:0]      in_req_tag,
    output logic [NUM_LANES-1:0]                 in_req_ready,
    output logic [NUM_LANES-1:0]                 dc_req_valid,
    output logic [NUM_LANES-1:0]                 dc_req_rw,
    output logic [NUM_LANES-1:0][ADDR_W-1:0]     dc_req_addr,
    output logic [NUM_LANES-1:0][DATA_W/8-1:0]   dc_req_byteen,
    output logic [NUM_LANES-1:0][DATA_W-1:0]     dc_req_data,
    output logic [NUM_LANES-1:0][TAG_W-1:0]      dc_req_tag,
    input  logic [NUM_LANES-1:0]                 dc_req_ready,
    output logic [NUM_LANES-1:0]                 smem_req_valid,
    output logic [NUM_LANES-1:0]                 smem_req_rw,
    output logic [NUM_LANES-1:0][ADDR_W-1:0]     smem_req_addr,
    output logic [NUM_LANES-1:0][DATA_W/8-1:0]   smem_req_byteen,
    output logic [NUM_LANES-1:0][DATA_W-1:0]     smem_req_data,
    output logic [NUM_LANES-1:0][TAG_W-1:0]      smem_req_tag,
    input  logic [NUM_LANES-1:0]                 smem_req_ready,
    input  logic                                 dc_rsp_valid,
    input  logic [NUM_LANES-1:0]                 dc_rsp_tmask,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]     dc_rsp_data,
    input  logic [TAG_W-1:0]                     dc_rsp_tag,
    output logic                                 dc_rsp_ready,
    input  logic                                 smem_rsp_valid,
    input  logic [NUM_LANES-1:0]                 smem_rsp_tmask,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]     smem_rsp_data,
    input  logic [TAG_W-1:0]                     smem_rsp_tag,
    output logic                                 smem_rsp_ready,
    output logic                                 out_rsp_valid,
    output logic [NUM_LANES-1:0]                 out_rsp_tmask,
    output logic [NUM_LANES-1:0][DATA_W-1:0]     out_rsp_data,
    output logic [TAG_W-1:0]                     out_rsp_tag,
    input  logic                                 out_rsp_ready
);
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [1:0]          cnt;
        logic                wp, rp, push, pop, dst;
        logic                dst_q [2];
        logic                rw_q [2];
        logic [ADDR_W-1:0]   addr_q [2];
        logic [DATA_W/8-1:0] be_q [2];
        logic [DATA_W-1:0]   data_q [2];
        logic [TAG_W-1:0]    tag_q [2];
        assign dst             = dst_q[rp];
        assign in_req_ready[i] = cnt != 2'd2;
        assign push            = in_req_valid[i] && in_req_ready[i];
        assign pop             = cnt != 2'd0 && (dst ? smem_req_ready[i] : dc_req_ready[i]);
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                cnt <= 2'd0;
                wp  <= 1'b0;
                rp  <= 1'b0;
            end else begin
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
                wp  <= wp ^ push;
                rp  <= rp ^ pop;
            end
        // Payload storage needs no reset; occupancy alone decides validity.
        always_ff @(posedge clk)
            if (push) begin
                dst_q[wp]  <= in_req_tag[i][SEL_BIT];
                rw_q[wp]   <= in_req_rw[i];
                addr_q[wp] <= in_req_addr[i];
                be_q[wp]   <= in_req_byteen[i];
                data_q[wp] <= in_req_data[i];
                tag_q[wp]  <= in_req_tag[i];
            end
        assign dc_req_valid[i]    = cnt != 2'd0 && !dst;
        assign smem_req_valid[i]  = cnt != 2'd0 && dst;
        assign dc_req_rw[i]       = rw_q[rp];
        assign dc_req_addr[i]     = addr_q[rp];
        assign dc_req_byteen[i]   = be_q[rp];
        assign dc_req_data[i]     = data_q[rp];
        assign dc_req_tag[i]      = tag_q[rp];
        assign smem_req_rw[i]     = rw_q[rp];
        assign smem_req_addr[i]   = addr_q[rp];
        assign smem_req_byteen[i] = be_q[rp];
        assign smem_req_data[i]   = data_q[rp];
        assign smem_req_tag[i]    = tag_q[rp];
    end
    logic last_smem, grant_dc, grant_smem, load;
    always_comb begin
        grant_dc       = dc_rsp_valid && (!smem_rsp_valid || last_smem);
        grant_smem     = smem_rsp_valid && !grant_dc;
        load           = !out_rsp_valid || out_rsp_ready;
        dc_rsp_ready   = grant_dc && load;
        smem_rsp_ready = grant_smem && load;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            last_smem     <= 1'b1;
            out_rsp_valid <= 1'b0;
            out_rsp_tmask <= '0;
            out_rsp_data  <= '0;
            out_rsp_tag   <= '0;
        end else if (load) begin
            out_rsp_valid <= grant_dc || grant_smem;
            out_rsp_tmask <= grant_dc ? dc_rsp_tmask : smem_rsp_tmask;
            out_rsp_data  <= grant_dc ? dc_rsp_data : smem_rsp_data;
            out_rsp_tag   <= grant_dc ? dc_rsp_tag : smem_rsp_tag;
            if (grant_dc || grant_smem)
                last_smem <= grant_smem;
        end
endmodule
